// File: rtl/count_seq_pkg.sv
// Shared state, phase and mode definitions for count_sequencer, plus the Moore output decode.
package count_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_BIN,
    S_GRAY,
    S_DONE
  } state_t;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_CLEAR = 2'd1;
  localparam logic [1:0] PH_BIN   = 2'd2;
  localparam logic [1:0] PH_GRAY  = 2'd3;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  typedef struct packed {
    logic       m;
    logic       cnt_en;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic [1:0] phase;
  } seq_out_t;

  // stall only gates the enable; mode and phase keep showing the current state
  function automatic seq_out_t decode_outputs(state_t s, logic stall);
    seq_out_t o;
    o = '0;
    unique case (s)
      S_IDLE:  o = '0;
      S_CLEAR: begin
        o.cnt_clr = 1'b1;
        o.busy    = 1'b1;
        o.m       = MODE_BIN;
        o.phase   = PH_CLEAR;
      end
      S_BIN: begin
        o.m      = MODE_BIN;
        o.cnt_en = ~stall;
        o.busy   = 1'b1;
        o.phase  = PH_BIN;
      end
      S_GRAY: begin
        o.m      = MODE_GRAY;
        o.cnt_en = ~stall;
        o.busy   = 1'b1;
        o.phase  = PH_GRAY;
      end
      S_DONE: begin
        o.busy  = 1'b1;
        o.done  = 1'b1;
        o.phase = PH_IDLE;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable down-counter timing one BIN or GRAY phase; o_zero marks the final enabled cycle.
module seq_phase_timer #(
  parameter int LEN_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [LEN_W-1:0] r_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count - LEN_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/count_sequencer.sv
// Schedules clear / binary / Gray phases of the mode counter over a number of passes.
// Optional Pause input stalls BIN/GRAY when COUNT_SEQUENCER_PAUSE_EN is defined.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int PASS_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [LEN_W-1:0]  BinCycles,
  input  logic [LEN_W-1:0]  GrayCycles,
  input  logic [PASS_W-1:0] Passes,
`ifdef COUNT_SEQUENCER_PAUSE_EN
  input  logic              Pause,
`endif
  output logic              M,
  output logic              CntEn,
  output logic              CntClr,
  output logic              Busy,
  output logic              Done,
  output logic [1:0]        Phase
);

  state_t            r_state;
  seq_out_t          r_out;
  logic [LEN_W-1:0]  r_bin;
  logic [LEN_W-1:0]  r_gray;
  logic [PASS_W-1:0] r_passes;
  logic [PASS_W-1:0] r_pass_cnt;

  logic              w_stall;
  logic              w_zero;
  logic              w_last;
  logic              w_load;
  logic [LEN_W-1:0]  w_load_val;
  logic [PASS_W-1:0] w_pass_next;
  logic              w_pass_more;

`ifdef COUNT_SEQUENCER_PAUSE_EN
  assign w_stall = Pause;
`else
  assign w_stall = 1'b0;
`endif

  // The registered enable doubles as "this cycle counts", so a stalled cycle never ticks the timer.
  assign w_last      = r_out.cnt_en & w_zero;
  assign w_load      = (r_state == S_CLEAR) | w_last;
  assign w_load_val  = ((r_state == S_BIN) && (r_gray != '0)) ? (r_gray - LEN_W'(1)) :
                       (r_bin != '0) ? (r_bin - LEN_W'(1)) : (r_gray - LEN_W'(1));
  assign w_pass_next = r_pass_cnt + PASS_W'(1);
  assign w_pass_more = (w_pass_next < r_passes);

  seq_phase_timer #(.LEN_W(LEN_W)) u_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (r_out.cnt_en & ~w_zero),
    .o_zero     (w_zero)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_out      <= '0;
      r_bin      <= '0;
      r_gray     <= '0;
      r_passes   <= '0;
      r_pass_cnt <= '0;
    end else begin
      r_out <= decode_outputs(r_state, w_stall);
      if (Abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_out   <= decode_outputs(S_IDLE, 1'b0);
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (Start) begin
              r_bin      <= BinCycles;
              r_gray     <= GrayCycles;
              r_passes   <= (Passes == '0) ? PASS_W'(1) : Passes;
              r_pass_cnt <= '0;
              r_state    <= S_CLEAR;
              r_out      <= decode_outputs(S_CLEAR, w_stall);
            end
          end
          S_CLEAR: begin
            if (r_bin != '0) begin
              r_state <= S_BIN;
              r_out   <= decode_outputs(S_BIN, w_stall);
            end else if (r_gray != '0) begin
              r_state <= S_GRAY;
              r_out   <= decode_outputs(S_GRAY, w_stall);
            end else begin
              r_state <= S_DONE;
              r_out   <= decode_outputs(S_DONE, w_stall);
            end
          end
          S_BIN, S_GRAY: begin
            if (w_last) begin
              if ((r_state == S_BIN) && (r_gray != '0)) begin
                r_state <= S_GRAY;
                r_out   <= decode_outputs(S_GRAY, w_stall);
              end else begin
                r_pass_cnt <= w_pass_next;
                if (!w_pass_more) begin
                  r_state <= S_DONE;
                  r_out   <= decode_outputs(S_DONE, w_stall);
                end else if (r_bin != '0) begin
                  r_state <= S_BIN;
                  r_out   <= decode_outputs(S_BIN, w_stall);
                end else begin
                  r_state <= S_GRAY;
                  r_out   <= decode_outputs(S_GRAY, w_stall);
                end
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_out   <= decode_outputs(S_IDLE, 1'b0);
          end
          default: begin
            r_state <= S_IDLE;
            r_out   <= '0;
          end
        endcase
      end
    end
  end

  assign M      = r_out.m;
  assign CntEn  = r_out.cnt_en;
  assign CntClr = r_out.cnt_clr;
  assign Busy   = r_out.busy;
  assign Done   = r_out.done;
  assign Phase  = r_out.phase;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: the schedule model pushes per-cycle expectations, a monitor pops them.
module tb_count_sequencer;

  localparam int LEN_W  = 8;
  localparam int PASS_W = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Start;
  logic              Abort;
  logic [LEN_W-1:0]  BinCycles;
  logic [LEN_W-1:0]  GrayCycles;
  logic [PASS_W-1:0] Passes;
  logic              Pause;
  logic              M, CntEn, CntClr, Busy, Done;
  logic [1:0]        Phase;

  always #5 Clk = ~Clk;

  count_sequencer #(.LEN_W(LEN_W), .PASS_W(PASS_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Abort      (Abort),
    .BinCycles  (BinCycles),
    .GrayCycles (GrayCycles),
    .Passes     (Passes),
`ifdef COUNT_SEQUENCER_PAUSE_EN
    .Pause      (Pause),
`endif
    .M          (M),
    .CntEn      (CntEn),
    .CntClr     (CntClr),
    .Busy       (Busy),
    .Done       (Done),
    .Phase      (Phase)
  );

  // Attached 3-bit binary/Gray counter
  logic [2:0] tb_cnt;
  always @(posedge Clk or posedge Reset) begin
    if (Reset)       tb_cnt <= 3'd0;
    else if (CntClr) tb_cnt <= 3'd0;
    else if (CntEn)  tb_cnt <= tb_cnt + 3'd1;
  end

  typedef struct {
    int unsigned cyc;
    logic [6:0]  outs;   // {M, CntEn, CntClr, Busy, Done, Phase}
    bit          cnt_chk;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        plan[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          mon_en = 1'b1;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [2:0] gray3(logic [2:0] v);
    return v ^ (v >> 1);
  endfunction

  // Whole schedule as a list of cycles: CLEAR, passes of B binary + G Gray counts, DONE.
  function automatic void build_plan(int unsigned b, int unsigned g, int unsigned p, int unsigned c0);
    int unsigned np;
    int unsigned n;
    exp_t e;
    np = (p == 0) ? 1 : p;
    n = 0;
    plan.delete();
    e.cyc = c0; e.outs = 7'b0011001; e.cnt_chk = 1'b0; e.cnt = 3'd0;
    plan.push_back(e);
    for (int unsigned k = 0; k < np; k++) begin
      for (int unsigned i = 0; i < b; i++) begin
        e.cyc = c0 + 1 + n; e.outs = 7'b0101010; e.cnt_chk = 1'b1; e.cnt = 3'(n);
        plan.push_back(e);
        n++;
      end
      for (int unsigned i = 0; i < g; i++) begin
        e.cyc = c0 + 1 + n; e.outs = 7'b1101011; e.cnt_chk = 1'b1; e.cnt = gray3(3'(n));
        plan.push_back(e);
        n++;
      end
    end
    e.cyc = c0 + 1 + n; e.outs = 7'b0001100; e.cnt_chk = 1'b1; e.cnt = 3'(n);
    plan.push_back(e);
  endfunction

  exp_t       m_e;
  logic [6:0] m_act;
  logic [2:0] m_disp;

  always @(negedge Clk) begin
    if (mon_en) begin
      m_act  = {M, CntEn, CntClr, Busy, Done, Phase};
      m_disp = M ? gray3(tb_cnt) : tb_cnt;
      if (Busy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy cyc=%0d got=%b", cyc, m_act);
        end else begin
          m_e = q.pop_front();
          if (m_e.cyc != cyc || m_e.outs != m_act || (m_e.cnt_chk && m_e.cnt != m_disp)) begin
            errors++;
            $display("FAIL sched_cycle cyc=%0d got=%b cnt=%0d exp_cyc=%0d exp=%b cnt=%0d",
                     cyc, m_act, m_disp, m_e.cyc, m_e.outs, m_e.cnt);
          end
        end
      end else begin
        checks++;
        if (m_act != 7'd0) begin
          errors++;
          $display("FAIL idle_outputs cyc=%0d got=%b exp=0000000", cyc, m_act);
        end
        if (q.size() != 0) begin
          checks++;
          if (q[0].cyc <= cyc) begin
            errors++;
            $display("FAIL missing_output cyc=%0d got=%b exp_cyc=%0d exp=%b", cyc, m_act, q[0].cyc, q[0].outs);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // mode 0: full run; 1: Abort sampled at end of offset a; 2: async Reset during offset a+1
  task automatic run(input int unsigned b, input int unsigned g, input int unsigned p,
                     input int mode, input int unsigned a);
    int unsigned c0, len, last;
    @(negedge Clk);
    c0 = cyc + 1;
    build_plan(b, g, p, c0);
    len  = plan.size();
    last = (mode == 0 || a >= len) ? len - 1 : a;
    for (int unsigned i = 0; i <= last; i++) q.push_back(plan[i]);
    BinCycles  = LEN_W'(b);
    GrayCycles = LEN_W'(g);
    Passes     = PASS_W'(p);
    Start      = 1'b1;
    for (int unsigned off = 0; off <= last; off++) begin
      @(negedge Clk);
      BinCycles  = LEN_W'($urandom);
      GrayCycles = LEN_W'($urandom);
      Passes     = PASS_W'($urandom);
      Start      = (off < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode != 0 && off == last) begin
        Start = 1'b0;
        if (mode == 1) Abort = 1'b1;
      end
    end
    if (mode == 1) begin
      @(negedge Clk);
      Abort = 1'b0;
    end else if (mode == 2) begin
      @(posedge Clk);
      #2 Reset = 1'b1;
      #1;
      checks++;
      if ({Busy, CntEn, M, CntClr, Done, Phase} != 7'd0) begin
        errors++;
        $display("FAIL async_reset got=%b exp=0000000", {Busy, CntEn, M, CntClr, Done, Phase});
      end
      @(negedge Clk);
      Reset = 1'b0;
    end
    for (int i = 0; i < 40 && (q.size() != 0 || Busy); i++) @(negedge Clk);
    checks++;
    if (q.size() != 0 || Busy) begin
      errors++;
      $display("FAIL completion_timeout pending=%0d busy=%0b exp=0/0", q.size(), Busy);
      q.delete();
    end
    repeat ($urandom_range(0, 3)) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Pause = 1'b0;
    BinCycles = '0; GrayCycles = '0; Passes = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);

    run(3, 2, 1, 0, 0);
    run(0, 4, 2, 0, 0);
    run(0, 0, 1, 0, 0);
    run(2, 1, 0, 0, 0);
    run(3, 5, 1, 1, 5);
    run(3, 2, 1, 0, 0);
    run(5, 3, 2, 2, 2);
    run(2, 3, 1, 2, 4);
    run(255, 1, 1, 0, 0);
    run(0, 255, 1, 1, 200);

`ifdef COUNT_SEQUENCER_PAUSE_EN
    begin
      int unsigned en_cnt;
      bit seen_done;
      mon_en = 1'b0;
      en_cnt = 0;
      seen_done = 1'b0;
      @(negedge Clk);
      BinCycles = 8'd4; GrayCycles = 8'd2; Passes = 4'd1; Start = 1'b1;
      for (int i = 0; i < 40 && !seen_done; i++) begin
        @(negedge Clk);
        Start = 1'b0;
        Pause = (i >= 2 && i <= 4);
        if (CntEn) en_cnt++;
        if (Done) seen_done = 1'b1;
      end
      Pause = 1'b0;
      checks++;
      if (!seen_done || en_cnt != 6) begin
        errors++;
        $display("FAIL pause_total got=%0d done=%0b exp=6 done=1", en_cnt, seen_done);
      end
      repeat (2) @(negedge Clk);
      mon_en = 1'b1;
    end
`endif

    for (int r = 0; r < 25; r++) begin
      int unsigned b, g, p, np, len, sel;
      b   = $urandom_range(0, 6);
      g   = $urandom_range(0, 6);
      p   = $urandom_range(0, 3);
      np  = (p == 0) ? 1 : p;
      len = 2 + np * (b + g);
      sel = $urandom_range(0, 9);
      if (sel < 6)      run(b, g, p, 0, 0);
      else if (sel < 8) run(b, g, p, 1, $urandom_range(0, len - 1));
      else              run(b, g, p, 2, $urandom_range(0, len - 1));
    end

    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
